// File: rtl/ps2_keycode_rx.sv
// ps2_keycode_rx: receive-only PS/2 keyboard deframer producing a rolling
// 16-bit keycode {previous byte, newest byte}; break codes show as 16'hF0xx.
// Latency: raw ps2_clk fall -> edge detect 2+FILTER_LEN clk; key_valid 1 clk later.
// Backpressure: none; the keyboard sets the pace, each result is a 1-cycle pulse.
//
// Ports:
//   clk        system clock, all logic on rising edge
//   rst        asynchronous active-low reset
//   ps2_clk    raw PS/2 clock (kclk), asynchronous to clk
//   ps2_data   raw PS/2 data (kdata), asynchronous to clk
//   keyc       {byte[n-1], byte[n]} of the last two good frames
//   key_valid  1-cycle pulse when keyc has just been updated
//   frame_err  1-cycle pulse on start/parity/stop error or mid-frame timeout

module ps2_keycode_rx #(
   parameter int FILTER_LEN  = 4,
   parameter int TIMEOUT_CYC = 65000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [15:0] keyc,
   output logic        key_valid,
   output logic        frame_err
);

   localparam int FW = (FILTER_LEN  > 1) ? $clog2(FILTER_LEN + 1)  : 1;
   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

   localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   // ------------------------------------------------------------------
   // Two-flop synchronisers; preset to 1 so reset looks like an idle bus.
   // ------------------------------------------------------------------
   logic clk_s1, clk_s2;
   logic dat_s1, dat_s2;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= ps2_clk;
         clk_s2 <= clk_s1;
         dat_s1 <= ps2_data;
         dat_s2 <= dat_s1;
      end
   end

   // ------------------------------------------------------------------
   // Glitch filter on the synced clock. filt_cnt counts consecutive
   // samples that disagree with the filtered value; any agreeing sample
   // restarts the count, so pulses shorter than FILTER_LEN are dropped.
   // ------------------------------------------------------------------
   logic          filt_clk;
   logic          filt_clk_d;
   logic [FW-1:0] filt_cnt;
   logic          fall;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         filt_clk   <= 1'b1;
         filt_clk_d <= 1'b1;
         filt_cnt   <= '0;
      end else begin
         filt_clk_d <= filt_clk;
         if (clk_s2 == filt_clk) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FILT_LAST) begin
            filt_clk <= clk_s2;
            filt_cnt <= '0;
         end else begin
            filt_cnt <= filt_cnt + 1'b1;
         end
      end
   end

   // Falling edge of the filtered clock; dat_s2 is the bit to sample now.
   assign fall = filt_clk_d & ~filt_clk;

   // ------------------------------------------------------------------
   // Frame FSM with registered outputs. Only falling edges advance it;
   // the timeout counter runs in every non-IDLE state and is cleared by
   // each falling edge, so a keyboard that stops mid-frame is abandoned.
   // ------------------------------------------------------------------
   state_t        state;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          par_bit;
   logic [TW-1:0] to_cnt;
   logic          timeout;

   // A falling edge in the same cycle counts as activity and wins.
   assign timeout = (state != IDLE) && !fall && (to_cnt == TO_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         par_bit   <= 1'b0;
         to_cnt    <= '0;
         keyc      <= 16'h0000;
         key_valid <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         frame_err <= 1'b0;

         if (state == IDLE || fall) begin
            to_cnt <= '0;
         end else begin
            to_cnt <= to_cnt + 1'b1;
         end

         if (timeout) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            to_cnt    <= '0;
            frame_err <= 1'b1;
         end else if (fall) begin
            unique case (state)
               IDLE: begin
                  // A high start bit is just line noise on an idle bus.
                  if (!dat_s2) begin
                     state   <= DATA;
                     bit_cnt <= '0;
                     shreg   <= '0;
                  end
               end
               DATA: begin
                  shreg <= {dat_s2, shreg[7:1]};   // LSB arrives first
                  if (bit_cnt == 3'd7) begin
                     state <= PARITY;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end
               PARITY: begin
                  par_bit <= dat_s2;
                  state   <= STOP;
               end
               STOP: begin
                  // Odd parity: data plus parity bit must hold an odd count of ones.
                  if (dat_s2 && (^{shreg, par_bit})) begin
                     keyc      <= {keyc[7:0], shreg};
                     key_valid <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
                  state   <= IDLE;
                  bit_cnt <= '0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
module tb_ps2_keycode_rx;

   localparam int FILTER_LEN  = 4;
   localparam int TIMEOUT_CYC = 1000;
   localparam int HALF        = 20;   // clk cycles per PS/2 half bit
   localparam int GAP         = 60;   // idle clk cycles between frames

   logic        clk;
   logic        rst;
   logic        ps2_clk;
   logic        ps2_data;
   logic [15:0] keyc;
   logic        key_valid;
   logic        frame_err;

   ps2_keycode_rx #(
      .FILTER_LEN  (FILTER_LEN),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .keyc      (keyc),
      .key_valid (key_valid),
      .frame_err (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          is_err;
      logic [15:0] keyc;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h", name, act, req);
      end
   endtask

   task automatic expect_key(input logic [15:0] k);
      exp_t e;
      e.is_err = 1'b0;
      e.keyc   = k;
      exp_q.push_back(e);
   endtask

   task automatic expect_err(input logic [15:0] k);
      exp_t e;
      e.is_err = 1'b1;
      e.keyc   = k;
      exp_q.push_back(e);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drive the first nbits of an 11-bit frame, bit 0 first; data changes
   // while ps2_clk is high, the keyboard-side convention.
   task automatic send_bits(input logic [10:0] bits, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         ps2_data = bits[i];
         wait_cyc(HALF);
         ps2_clk = 1'b0;
         wait_cyc(HALF);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
      send_bits({stop, par, b, 1'b0}, 11);
      wait_cyc(GAP);
   endtask

   // Monitor: pops one expectation per output pulse.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (key_valid || frame_err) begin
            check("pulse_exclusive", {31'd0, key_valid & frame_err}, 32'd0);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_pulse: actual valid=%0b err=%0b keyc=%h required no pulse",
                        key_valid, frame_err, keyc);
            end else begin
               e = exp_q.pop_front();
               check("pulse_kind_err", {31'd0, frame_err}, {31'd0, e.is_err});
               check("keyc_at_pulse", {16'd0, keyc}, {16'd0, e.keyc});
            end
         end
      end
   end

   initial begin
      int budget;
      rst      = 1'b0;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      wait_cyc(3);
      check("reset_keyc", {16'd0, keyc}, 32'h0000);
      check("reset_key_valid", {31'd0, key_valid}, 32'd0);
      check("reset_frame_err", {31'd0, frame_err}, 32'd0);
      rst = 1'b1;
      wait_cyc(10);

      // 1: 0x1C, parity 0
      expect_key(16'h001C);
      send_frame(8'h1C, 1'b0, 1'b1);
      // 2: break sequence F0 1C
      expect_key(16'h1CF0);
      send_frame(8'hF0, 1'b1, 1'b1);
      expect_key(16'hF01C);
      send_frame(8'h1C, 1'b0, 1'b1);
      // 3: bad parity
      expect_err(16'hF01C);
      send_frame(8'h1C, 1'b1, 1'b1);
      // 4: bad stop bit, then good 0x23
      expect_err(16'hF01C);
      send_frame(8'h23, 1'b0, 1'b0);
      expect_key(16'h1C23);
      send_frame(8'h23, 1'b0, 1'b1);
      // 5: stall after 5 bits (start + 4 data bits of 0x29)
      expect_err(16'h1C23);
      send_bits({1'b1, 1'b0, 8'h29, 1'b0}, 5);
      wait_cyc(TIMEOUT_CYC + 10);
      check("keyc_after_timeout", {16'd0, keyc}, 32'h1C23);
      expect_key(16'h2329);
      send_frame(8'h29, 1'b0, 1'b1);
      // 6a: 2-cycle low glitch with data low in IDLE must not start a frame
      ps2_data = 1'b0;
      wait_cyc(5);
      ps2_clk = 1'b0;
      wait_cyc(2);
      ps2_clk = 1'b1;
      wait_cyc(30);
      ps2_data = 1'b1;
      wait_cyc(GAP);
      expect_key(16'h29F0);
      send_frame(8'hF0, 1'b1, 1'b1);
      // 6b: reset mid-frame, then clean reception and a typematic repeat
      send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 4);
      wait_cyc(5);
      rst = 1'b0;
      wait_cyc(5);
      check("keyc_in_midframe_reset", {16'd0, keyc}, 32'h0000);
      rst = 1'b1;
      wait_cyc(GAP);
      check("keyc_after_midframe_reset", {16'd0, keyc}, 32'h0000);
      expect_key(16'h001C);
      send_frame(8'h1C, 1'b0, 1'b1);
      expect_key(16'h1C1C);
      send_frame(8'h1C, 1'b0, 1'b1);
      wait_cyc(100);
      check("keyc_hold", {16'd0, keyc}, 32'h1C1C);

      budget = 0;
      while (exp_q.size() != 0 && budget < 2000) begin
         wait_cyc(1);
         budget++;
      end
      check("pending_expectations", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
